// File: rtl/seq_pattern_tx_101_pkg.sv
// Shared definitions for the "101" link transmitter: state encoding and line-pattern constants.
package seq_pattern_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE_A  = 3'd1,
        ST_PRE_B  = 3'd2,
        ST_PRE_C  = 3'd3,
        ST_DATA   = 3'd4,
        ST_STUFF  = 3'd5,
        ST_PARITY = 3'd6,
        ST_GUARD  = 3'd7
    } state_t;

    localparam logic [2:0] PREAMBLE     = 3'b101;
    // Two-bit line history (older bit first) after which a 1 would complete "101".
    localparam logic [1:0] STUFF_PREFIX = 2'b10;

endpackage

// File: rtl/seq_pattern_tx_101_if.sv
// Word handshake between a producer (master) and the serial transmitter (slave).
interface seq_pattern_tx_101_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_pattern_tx_101.sv
// Serial "101"-preamble frame transmitter with zero-stuffing so a line detector fires once per frame.
// Optional even-parity bit after the payload when SEQ_PATTERN_TX_PARITY_EN is defined.
module seq_pattern_tx_101
    import seq_pattern_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GUARD  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seq_pattern_tx_101_if.slave  in_if,
    output logic                 out,
    output logic [2:0]           state,
    output logic                 busy
);

    localparam int         CNT_W      = $clog2(DATA_W + 1);
    localparam logic [3:0] GUARD_INIT = 4'(GUARD - 1);

    state_t              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [CNT_W-1:0]    bit_cnt;
    logic [3:0]          guard_cnt;
    logic [1:0]          hist;
    logic [1:0]          hist_now;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    logic                par_q;
`endif

    // Line history including the bit currently on the wire; decides stuffing for the next bit.
    assign hist_now = {hist[0], out};

    assign in_if.in_ready = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign state          = state_q;

    function automatic logic need_stuff(input logic [1:0] h, input logic b);
        return (h == STUFF_PREFIX) && b;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            out       <= 1'b0;
            shift_q   <= '0;
            bit_cnt   <= '0;
            guard_cnt <= '0;
            hist      <= '0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            hist <= (state_q == ST_IDLE) ? 2'b00 : hist_now;
            case (state_q)
                ST_IDLE: begin
                    out <= 1'b0;
                    if (in_if.in_valid) begin
                        shift_q <= in_if.in_data;
                        bit_cnt <= CNT_W'(DATA_W);
`ifdef SEQ_PATTERN_TX_PARITY_EN
                        par_q   <= ^in_if.in_data;
`endif
                        state_q <= ST_PRE_A;
                        out     <= PREAMBLE[2];
                    end
                end
                ST_PRE_A: begin
                    state_q <= ST_PRE_B;
                    out     <= PREAMBLE[1];
                end
                ST_PRE_B: begin
                    state_q <= ST_PRE_C;
                    out     <= PREAMBLE[0];
                end
                ST_PRE_C, ST_DATA: begin
                    if (bit_cnt != '0) begin
                        if (need_stuff(hist_now, shift_q[DATA_W-1])) begin
                            state_q <= ST_STUFF;
                            out     <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                            out     <= shift_q[DATA_W-1];
                            shift_q <= shift_q << 1;
                            bit_cnt <= bit_cnt - CNT_W'(1);
                        end
                    end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                        if (need_stuff(hist_now, par_q)) begin
                            state_q <= ST_STUFF;
                            out     <= 1'b0;
                        end else begin
                            state_q <= ST_PARITY;
                            out     <= par_q;
                        end
`else
                        state_q   <= ST_GUARD;
                        out       <= 1'b0;
                        guard_cnt <= GUARD_INIT;
`endif
                    end
                end
                // A stuffed zero is always followed by the bit it deferred.
                ST_STUFF: begin
                    if (bit_cnt != '0) begin
                        state_q <= ST_DATA;
                        out     <= shift_q[DATA_W-1];
                        shift_q <= shift_q << 1;
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                        state_q <= ST_PARITY;
                        out     <= par_q;
`else
                        state_q   <= ST_GUARD;
                        out       <= 1'b0;
                        guard_cnt <= GUARD_INIT;
`endif
                    end
                end
`ifdef SEQ_PATTERN_TX_PARITY_EN
                ST_PARITY: begin
                    state_q   <= ST_GUARD;
                    out       <= 1'b0;
                    guard_cnt <= GUARD_INIT;
                end
`endif
                ST_GUARD: begin
                    out <= 1'b0;
                    if (guard_cnt == 4'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        guard_cnt <= guard_cnt - 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    out     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx_101.sv
// Directed + random bench for seq_pattern_tx_101 against a bit-list model of the framing rules.
module tb_seq_pattern_tx_101;
    import seq_pattern_pkg::*;

    localparam int DATA_W  = 8;
    localparam int GUARD_N = 2;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       out;
    logic       busy;
    logic [2:0] state;

    seq_pattern_tx_101_if #(.DATA_W(DATA_W)) bus ();

    seq_pattern_tx_101 #(.DATA_W(DATA_W), .GUARD(GUARD_N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_if   (bus),
        .out     (out),
        .state   (state),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Model: append a line bit, inserting a 0 first if the wire would otherwise show "101".
    task automatic push_bit(input bit b);
        int n;
        n = exp_q.size();
        if (b && exp_q[n-2] == 1'b1 && exp_q[n-1] == 1'b0) exp_q.push_back(1'b0);
        exp_q.push_back(b);
    endtask

    task automatic build(input logic [DATA_W-1:0] w);
        exp_q.delete();
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int k = DATA_W - 1; k >= 0; k--) push_bit(w[k]);
`ifdef SEQ_PATTERN_TX_PARITY_EN
        push_bit(^w);
`endif
        for (int k = 0; k < GUARD_N; k++) exp_q.push_back(1'b0);
    endtask

    // Called at a falling edge; returns at the falling edge of the PRE_A cycle.
    task automatic send(input logic [DATA_W-1:0] w);
        int t;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("ready_before_send", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = DATA_W'($urandom);
    endtask

    task automatic check_frame(input logic [DATA_W-1:0] w, input int exp_len);
        int busy_cnt;
        int n;
        busy_cnt = 0;
        build(w);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("out_%0h_bit%0d", w, i), out, exp_q[i]);
            if (i < 3) check($sformatf("state_pre_%0d", i), state, i + 1);
            if (busy) busy_cnt++;
            bus.in_valid = (i < n - 1) ? 1'($urandom) : 1'b0;
            bus.in_data  = DATA_W'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        while (busy === 1'b1 && busy_cnt < 200) begin
            busy_cnt++;
            @(negedge clk);
        end
        check($sformatf("frame_len_%0h", w), busy_cnt, (exp_len < 0) ? n : exp_len);
        check("idle_ready", bus.in_ready, 1);
        check("idle_state", state, 0);
        check("idle_out", out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit q1[$];
        bit q2[$];
        bit exp_s[$];
        bit obs[$];
        int hits;
        int hit_pos[$];
        int ok;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset state
        #2;
        check("rst_out", out, 0);
        check("rst_state", state, 0);
        check("rst_ready", bus.in_ready, 1);
        check("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed frames
        send(8'hFF); check_frame(8'hFF, 13 + PAR);
        send(8'h55); check_frame(8'h55, 17 + PAR);
        send(8'hAA); check_frame(8'hAA, 16 + PAR);
        send(8'h00); check_frame(8'h00, 13 + PAR);
        send(8'h01); check_frame(8'h01, 13 + PAR);

        // Random payloads against the model
        for (int r = 0; r < 8; r++) begin
            logic [DATA_W-1:0] w;
            w = DATA_W'($urandom);
            send(w);
            check_frame(w, -1);
        end

        // Back-to-back frames with in_valid held high
        build(8'h55); q1 = exp_q;
        build(8'hAA); q2 = exp_q;
        exp_s = q1;
        exp_s.push_back(1'b0);
        foreach (q2[i]) exp_s.push_back(q2[i]);
        ok = 0;
        while (bus.in_ready !== 1'b1 && ok < 200) begin @(negedge clk); ok++; end
        check("b2b_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        @(posedge clk);
        @(negedge clk);
        bus.in_data = 8'hAA;
        obs.delete();
        for (int i = 0; i < exp_s.size(); i++) begin
            obs.push_back(out);
            check($sformatf("b2b_bit%0d", i), out, exp_s[i]);
            if (i == q1.size() + 1) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        hits = 0;
        hit_pos.delete();
        for (int i = 2; i < obs.size(); i++) begin
            if (obs[i-2] == 1'b1 && obs[i-1] == 1'b0 && obs[i] == 1'b1) begin
                hits++;
                hit_pos.push_back(i);
            end
        end
        check("b2b_detect_count", hits, 2);
        if (hits == 2) begin
            check("b2b_detect1_pos", hit_pos[0], 2);
            check("b2b_detect2_pos", hit_pos[1], q1.size() + 3);
            // Cycles from the first frame's last payload bit to the second PRE_A.
            check("b2b_gap", (hit_pos[1] - 2) - (q1.size() - GUARD_N - 1), GUARD_N + 2);
        end
        check("b2b_end_idle", state, 0);

        // Asynchronous reset in the middle of a frame
        send(8'h55);
        repeat (5) @(negedge clk);
        check("mid_state_data", state, 4);
        check("mid_out", out, 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_out", out, 0);
        check("async_rst_state", state, 0);
        check("async_rst_ready", bus.in_ready, 1);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle_state", state, 0);
            check("post_rst_idle_out", out, 0);
        end
        send(8'hFF); check_frame(8'hFF, 13 + PAR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
